feature_stream_tx: RTL and testbench

Packs the 75 flattened 16-bit features of one image into the 3-lane beat stream the dense classifier consumes, one frame at a time. Sits between the last pooling stage (serial sample source) and the dense stage's `data_in`/`data_in_valid` input. The dense stage has no backpressure, so this block is the sole owner of beat pacing and frame boundaries.

---
 rtl/feature_stream_tx.sv | 138 +++++++++++++
 tb/tb_feature_stream_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_stream_tx.sv
// Collects one frame of serial feature samples, then replays it as fixed-rate
// multi-lane beats for a sink that has no backpressure.
module feature_stream_tx #(
  parameter int DATA_W = 16,
  parameter int LANES  = 3,
  parameter int BEATS  = 25,
  parameter int GAP    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         pix_in,
  input  logic                      pix_in_valid,
  output logic                      pix_in_ready,
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic                      data_out_valid,
  output logic                      frame_done,
  output logic [7:0]                frame_cnt
);

  localparam int NSAMP  = LANES * BEATS;
  localparam int PTR_W  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {S_FILL, S_SEND, S_GAP, S_DONE} state_t;

  state_t                   state, state_nx;
  logic [PTR_W-1:0]         wr_ptr, wr_ptr_nx;
  logic [BEAT_W-1:0]        rd_beat, rd_beat_nx;
  logic [GAP_W-1:0]         gap_cnt, gap_cnt_nx;
  logic [DATA_W-1:0]        sample_buf [NSAMP];
  logic                     wr_en;
  logic [PTR_W-1:0]         beat_base;
  logic [LANES*DATA_W-1:0]  beat_data;
  logic [LANES*DATA_W-1:0]  data_out_nx;
  logic                     valid_nx;
  logic                     done_nx;
  logic [7:0]               frame_cnt_nx;

  // Beat b, lane k is sample 3b+k, matching the dense stage's flatten order.
  always_comb begin
    beat_data = '0;
    beat_base = PTR_W'(rd_beat) * PTR_W'(LANES);
    for (int k = 0; k < LANES; k++) begin
      beat_data[k*DATA_W +: DATA_W] = sample_buf[beat_base + PTR_W'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    rd_beat_nx   = rd_beat;
    gap_cnt_nx   = gap_cnt;
    wr_en        = 1'b0;
    data_out_nx  = data_out;
    valid_nx     = 1'b0;
    done_nx      = 1'b0;
    frame_cnt_nx = frame_cnt;
    if (flush) begin
      state_nx   = S_FILL;
      wr_ptr_nx  = '0;
      rd_beat_nx = '0;
      gap_cnt_nx = '0;
    end else begin
      case (state)
        S_FILL: begin
          if (pix_in_valid && pix_in_ready) begin
            wr_en = 1'b1;
            if (wr_ptr == PTR_W'(NSAMP - 1)) begin
              state_nx   = S_SEND;
              wr_ptr_nx  = '0;
              rd_beat_nx = '0;
            end else begin
              wr_ptr_nx = wr_ptr + PTR_W'(1);
            end
          end
        end
        S_SEND: begin
          data_out_nx = beat_data;
          valid_nx    = 1'b1;
          if (rd_beat == BEAT_W'(BEATS - 1)) begin
            state_nx = S_DONE;
          end else begin
            rd_beat_nx = rd_beat + BEAT_W'(1);
            if (GAP > 0) begin
              state_nx   = S_GAP;
              gap_cnt_nx = '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP - 1)) state_nx = S_SEND;
          else                            gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
        S_DONE: begin
          done_nx      = 1'b1;
          frame_cnt_nx = frame_cnt + 8'd1;
          state_nx     = S_FILL;
        end
        default: state_nx = S_FILL;
      endcase
    end
  end

  // Output stage: every port is a register loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_beat        <= '0;
      gap_cnt        <= '0;
      pix_in_ready   <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= 8'd0;
    end else begin
      wr_ptr         <= wr_ptr_nx;
      rd_beat        <= rd_beat_nx;
      gap_cnt        <= gap_cnt_nx;
      pix_in_ready   <= (state_nx == S_FILL);
      data_out       <= data_out_nx;
      data_out_valid <= valid_nx;
      frame_done     <= done_nx;
      frame_cnt      <= frame_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) sample_buf[wr_ptr] <= pix_in;
  end

endmodule

// File: tb/tb_feature_stream_tx.sv
// Bench for feature_stream_tx: table-driven frames, queue-based frame model,
// and hand-written pacing, hold, flush and reset sequences.
module tb_feature_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] pix_in;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [47:0] data_out;
  logic        data_out_valid;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  logic        flush_g;
  logic [15:0] pix_in_g;
  logic        pix_in_valid_g;
  logic        pix_in_ready_g;
  logic [47:0] data_out_g;
  logic        data_out_valid_g;
  logic        frame_done_g;
  logic [7:0]  frame_cnt_g;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  feature_stream_tx #(.DATA_W(16), .LANES(3), .BEATS(25), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pix_in(pix_in),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  feature_stream_tx #(.DATA_W(16), .LANES(3), .BEATS(25), .GAP(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .flush(flush_g), .pix_in(pix_in_g),
    .pix_in_valid(pix_in_valid_g), .pix_in_ready(pix_in_ready_g),
    .data_out(data_out_g), .data_out_valid(data_out_valid_g),
    .frame_done(frame_done_g), .frame_cnt(frame_cnt_g)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: accepted samples gathered into frames of 75, each frame
  // expands to 25 beats of three consecutive samples.
  typedef struct { logic [47:0] d; bit last; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] acc_q[$];
  logic [47:0] got_beats[$];
  exp_t        e_new;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || flush) begin
        acc_q.delete();
        exp_q.delete();
      end else if (pix_in_valid && pix_in_ready) begin
        acc_q.push_back(pix_in);
        if (acc_q.size() == 75) begin
          for (int b = 0; b < 25; b++) begin
            e_new.d    = {acc_q[3*b+2], acc_q[3*b+1], acc_q[3*b]};
            e_new.last = (b == 24);
            exp_q.push_back(e_new);
          end
          acc_q.delete();
        end
      end
    end
  end

  initial begin
    logic [7:0] model_cnt;
    bit         done_pending;
    bit         want_done;
    exp_t       e_pop;
    model_cnt    = 8'd0;
    done_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_cnt    = 8'd0;
        done_pending = 1'b0;
      end else begin
        want_done    = done_pending;
        done_pending = 1'b0;
        if (data_out_valid) begin
          got_beats.push_back(data_out);
          if (exp_q.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL beat_unexpected: got 0x%0h, expected no beat", data_out);
          end else begin
            e_pop = exp_q.pop_front();
            check("beat_data", {16'h0, data_out}, {16'h0, e_pop.d});
            done_pending = e_pop.last;
          end
        end
        if (frame_done || want_done) begin
          check("frame_done", {63'h0, frame_done}, {63'h0, want_done});
          if (want_done) begin
            model_cnt = model_cnt + 8'd1;
            check("frame_cnt_on_done", {56'h0, frame_cnt}, {56'h0, model_cnt});
          end
        end
      end
    end
  end

  // Offers count samples base, base+step, ...; leaves the last one asserted.
  task automatic send_samples(input logic [15:0] base, input logic [15:0] step,
                              input int count, input bit bubbles);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < count && guard < 3000) begin
      @(negedge clk);
      guard++;
      pix_in       = base + 16'(i) * step;
      pix_in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pix_in_valid && pix_in_ready) i++;
    end
    if (i < count) begin
      nchecks++;
      nerr++;
      $display("FAIL send_timeout: got %0d samples accepted, expected %0d", i, count);
    end
  endtask

  task automatic wait_done(output int first_v, output int last_v, output int done_c, output bit ok);
    first_v = -1;
    last_v  = -1;
    done_c  = -1;
    ok      = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (data_out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (frame_done) begin
        done_c = c;
        ok     = 1'b1;
        break;
      end
    end
    nchecks++;
    if (!ok) begin
      nerr++;
      $display("FAIL frame_done_timeout: got no frame_done, expected one within 400 cycles");
    end
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    bit          bubbles;
    logic [47:0] b0;
    logic [47:0] b24;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   fv, lv, dc, n, nvalid, acc_c, bad_sp, bad_d, done_at;
    bit   ok, viol, seen;
    int   vt[$];
    logic [47:0] vd[$];
    logic [7:0]  exp_frames;

    vecs[0] = '{16'd1,     16'd1,     1'b0, {16'd3, 16'd2, 16'd1},          {16'd75, 16'd74, 16'd73}};
    vecs[1] = '{16'h8000,  16'd1,     1'b1, {16'h8002, 16'h8001, 16'h8000}, {16'h804A, 16'h8049, 16'h8048}};
    vecs[2] = '{16'hFFB5,  16'd1,     1'b1, {16'hFFB7, 16'hFFB6, 16'hFFB5}, {16'hFFFF, 16'hFFFE, 16'hFFFD}};
    vecs[3] = '{16'h0000,  16'h0101,  1'b1, {16'h0202, 16'h0101, 16'h0000}, {16'h4A4A, 16'h4949, 16'h4848}};

    rst_n = 1'b0; flush = 1'b0; pix_in = '0; pix_in_valid = 1'b0;
    flush_g = 1'b0; pix_in_g = '0; pix_in_valid_g = 1'b0;
    exp_frames = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_ready",      {63'h0, pix_in_ready},   64'h0);
    check("rst_data_out",   {16'h0, data_out},       64'h0);
    check("rst_valid",      {63'h0, data_out_valid}, 64'h0);
    check("rst_frame_done", {63'h0, frame_done},     64'h0);
    check("rst_frame_cnt",  {56'h0, frame_cnt},      64'h0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {63'h0, pix_in_ready}, 64'h0);
    @(negedge clk);
    check("ready_after_release", {63'h0, pix_in_ready}, 64'h1);

    // GAP=2 instance: pulses every third cycle, same beat contents.
    n = 0; acc_c = -1; done_at = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (data_out_valid_g) begin
        vt.push_back(c);
        vd.push_back(data_out_g);
      end
      if (frame_done_g) begin
        done_at = c;
        check("gap_ready_at_done", {63'h0, pix_in_ready_g}, 64'h1);
        check("gap_frame_cnt", {56'h0, frame_cnt_g}, 64'h1);
        break;
      end
      if (n < 75) begin
        pix_in_g = 16'(n + 1);
        pix_in_valid_g = 1'b1;
        if (pix_in_ready_g) begin
          n++;
          acc_c = c;
        end
      end else begin
        pix_in_valid_g = 1'b0;
      end
    end
    pix_in_valid_g = 1'b0;
    check("gap_pulse_count", 64'(vt.size()), 64'd25);
    if (vt.size() == 25) begin
      bad_sp = 0; bad_d = 0;
      for (int b = 0; b < 25; b++) begin
        if (b > 0 && vt[b] - vt[b-1] != 3) bad_sp++;
        if (vd[b] !== {16'(3*b+3), 16'(3*b+2), 16'(3*b+1)}) bad_d++;
      end
      check("gap_spacing_errors", 64'(bad_sp), 64'd0);
      check("gap_data_errors", 64'(bad_d), 64'd0);
      check("gap_first_latency", 64'(vt[0] - acc_c), 64'd2);
      check("gap_done_after_last", 64'(done_at - vt[24]), 64'd1);
    end

    // Table of whole frames through the GAP=0 instance.
    for (int t = 0; t < 4; t++) begin
      got_beats.delete();
      send_samples(vecs[t].base, vecs[t].step, 75, vecs[t].bubbles);
      @(negedge clk);
      pix_in_valid = 1'b0;
      wait_done(fv, lv, dc, ok);
      exp_frames = exp_frames + 8'd1;
      check("tbl_beat_count", 64'(got_beats.size()), 64'd25);
      if (got_beats.size() == 25) begin
        check("tbl_beat0", {16'h0, got_beats[0]}, {16'h0, vecs[t].b0});
        check("tbl_beat24", {16'h0, got_beats[24]}, {16'h0, vecs[t].b24});
      end
      check("tbl_hold_last", {16'h0, data_out}, {16'h0, vecs[t].b24});
      check("tbl_frame_cnt", {56'h0, frame_cnt}, {56'h0, exp_frames});
      check("tbl_ready_at_done", {63'h0, pix_in_ready}, 64'h1);
      if (ok) begin
        check("tbl_beats_contiguous", 64'(lv - fv), 64'd24);
        check("tbl_done_after_last", 64'(dc - lv), 64'd1);
      end
    end

    // Sample held through SEND must wait for ready, then lead the next frame.
    send_samples(16'd1, 16'd1, 75, 1'b0);
    viol = 1'b0; nvalid = 0; n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      pix_in = 16'hDEAD;
      pix_in_valid = 1'b1;
      if (data_out_valid) nvalid++;
      if (data_out_valid && pix_in_ready) viol = 1'b1;
      if (pix_in_ready) begin
        n = c;
        break;
      end
    end
    exp_frames = exp_frames + 8'd1;
    check("hold_accept_cycle", 64'(n), 64'd27);
    check("hold_beats_before_ready", 64'(nvalid), 64'd25);
    check("hold_ready_during_send", {63'h0, viol}, 64'h0);
    got_beats.delete();
    send_samples(16'd200, 16'd1, 74, 1'b0);
    @(negedge clk);
    pix_in_valid = 1'b0;
    wait_done(fv, lv, dc, ok);
    exp_frames = exp_frames + 8'd1;
    if (got_beats.size() > 0)
      check("hold_next_beat0", {16'h0, got_beats[0]}, {16'h0, 16'd201, 16'd200, 16'hDEAD});
    else
      check("hold_next_beat_count", 64'(got_beats.size()), 64'd25);

    // Flush at beat 10 aborts the frame without frame_done.
    send_samples(16'd300, 16'd1, 75, 1'b0);
    @(negedge clk);
    pix_in_valid = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 100; c++) begin
      if (data_out_valid) nvalid++;
      if (nvalid == 10) break;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid_low", {63'h0, data_out_valid}, 64'h0);
    check("flush_ready", {63'h0, pix_in_ready}, 64'h1);
    check("flush_frame_cnt", {56'h0, frame_cnt}, {56'h0, exp_frames});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (data_out_valid || frame_done) seen = 1'b1;
    end
    check("flush_quiet", {63'h0, seen}, 64'h0);
    // Partial frame, then a flush with a sample offered: both discarded.
    send_samples(16'h1111, 16'd1, 20, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    pix_in = 16'h0BAD;
    pix_in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    pix_in_valid = 1'b0;
    got_beats.delete();
    send_samples(16'd400, 16'd1, 75, 1'b1);
    @(negedge clk);
    pix_in_valid = 1'b0;
    wait_done(fv, lv, dc, ok);
    exp_frames = exp_frames + 8'd1;
    check("flush_fresh_frame_cnt", {56'h0, frame_cnt}, {56'h0, exp_frames});
    if (got_beats.size() > 0)
      check("flush_fresh_beat0", {16'h0, got_beats[0]}, {16'h0, 16'd402, 16'd401, 16'd400});

    // Asynchronous reset mid-fill.
    send_samples(16'd500, 16'd1, 40, 1'b0);
    @(negedge clk);
    pix_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready",      {63'h0, pix_in_ready},   64'h0);
    check("async_rst_data_out",   {16'h0, data_out},       64'h0);
    check("async_rst_valid",      {63'h0, data_out_valid}, 64'h0);
    check("async_rst_frame_done", {63'h0, frame_done},     64'h0);
    check("async_rst_frame_cnt",  {56'h0, frame_cnt},      64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 8'd0;
    got_beats.delete();
    send_samples(16'd101, 16'd1, 75, 1'b0);
    @(negedge clk);
    pix_in_valid = 1'b0;
    wait_done(fv, lv, dc, ok);
    exp_frames = exp_frames + 8'd1;
    check("post_rst_frame_cnt", {56'h0, frame_cnt}, {56'h0, exp_frames});
    if (got_beats.size() > 0)
      check("post_rst_beat0", {16'h0, got_beats[0]}, {16'h0, 16'd103, 16'd102, 16'd101});
    check("post_rst_beat_count", 64'(got_beats.size()), 64'd25);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected completion within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
